scan_test_ctrl: RTL and testbench

//  Sequencer for one scan chain built from the library dff cells (NbarT/Si scan mux).
//  Per test: shifts a pattern in serially, pulses one capture cycle, then shifts the response out and

---
 rtl/scan_ctrl_pkg.sv | 21 ++
 rtl/scan_misr16.sv | 35 +++
 rtl/scan_test_ctrl.sv | 166 ++++++++++++++++
 tb/tb_scan_test_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan test controller: FSM state encoding
// and the 16-bit signature register seed/taps.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShiftIn,
        StCapture,
        StUnload,
        StDone
    } state_e;

    localparam logic [15:0] MISR_SEED = 16'hFFFF;
    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] MISR_TAPS = 16'hB400;

    function automatic logic misr_feedback(input logic [15:0] sig, input logic din);
        return (^(sig & MISR_TAPS)) ^ din;
    endfunction

endpackage

// File: rtl/scan_misr16.sv
// 16-bit serial signature register fed by the scan-out stream; used by
// scan_test_ctrl only when SCAN_TEST_CTRL_MISR_EN is defined.
module scan_misr16
    import scan_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        din_i,
    output logic [15:0] sig_o
);

    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = MISR_SEED;
        end else if (enable_i) begin
            sig_d = {sig_q[14:0], misr_feedback(sig_q, din_i)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan chain test sequencer: shift pattern in, capture once, shift response out and
// count mismatches. Optional signature output enabled by SCAN_TEST_CTRL_MISR_EN.
module scan_test_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter  int unsigned CHAIN_LEN = 8,
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 C,
    input  logic                 CLRbar,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 so_in,
    output logic                 NbarT,
    output logic                 Si,
    output logic                 CE,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
`ifdef SCAN_TEST_CTRL_MISR_EN
    output logic [15:0]          sig,
`endif
    output logic [CNT_W-1:0]     mismatch_cnt
);

    localparam int unsigned    IDX_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAIN_LEN - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
    logic [CHAIN_LEN-1:0] expected_q, expected_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fail_q, fail_d;
    logic                 nbart_q, nbart_d;
    logic                 si_q, si_d;
    logic                 ce_q, ce_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 unload_en;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pattern_d  = pattern_q;
        expected_d = expected_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        accept     = 1'b0;
        unload_en  = 1'b0;

        // abort beats everything, including a start in the same IDLE cycle.
        if (abort) begin
            if (state_q != StIdle) begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        accept     = 1'b1;
                        state_d    = StShiftIn;
                        idx_d      = '0;
                        pattern_d  = pattern;
                        expected_d = expected;
                        cnt_d      = '0;
                        fail_d     = 1'b0;
                    end
                end
                StShiftIn: begin
                    pattern_d = pattern_q << 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = StCapture;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                StCapture: begin
                    state_d = StUnload;
                end
                StUnload: begin
                    unload_en  = 1'b1;
                    expected_d = expected_q << 1;
                    if (so_in != expected_q[CHAIN_LEN-1]) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = StDone;
                        fail_d  = (cnt_d != '0);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Outputs are registered, so they are decoded from the next state.
        nbart_d = (state_d == StShiftIn) || (state_d == StUnload);
        ce_d    = (state_d == StCapture);
        si_d    = (state_d == StShiftIn) ? pattern_d[CHAIN_LEN-1] : 1'b0;
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge C or negedge CLRbar) begin
        if (!CLRbar) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pattern_q  <= '0;
            expected_q <= '0;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            nbart_q    <= 1'b0;
            si_q       <= 1'b0;
            ce_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pattern_q  <= pattern_d;
            expected_q <= expected_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            nbart_q    <= nbart_d;
            si_q       <= si_d;
            ce_q       <= ce_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign NbarT        = nbart_q;
    assign Si           = si_q;
    assign CE           = ce_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign mismatch_cnt = cnt_q;

`ifdef SCAN_TEST_CTRL_MISR_EN
    scan_misr16 u_misr (
        .clk_i   (C),
        .rst_ni  (CLRbar),
        .clear_i (accept),
        .enable_i(unload_en),
        .din_i   (so_in),
        .sig_o   (sig)
    );
`else
    logic unused_misr;
    assign unused_misr = accept ^ unload_en;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Directed bench for scan_test_ctrl with a 4-cell scan chain whose capture value is 4'b0110.
// Define SCAN_TEST_CTRL_MISR_EN to also check the signature output.
module tb_scan_test_ctrl;

    localparam int          N           = 4;
    localparam logic [3:0]  CAPTURE_VAL = 4'b0110;

    logic       C = 1'b0;
    logic       CLRbar = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pattern = '0;
    logic [3:0] expected = '0;
    logic       so_in;
    logic       NbarT, Si, CE, busy, done, fail;
    logic [2:0] mismatch_cnt;
    logic [3:0] chain;
`ifdef SCAN_TEST_CTRL_MISR_EN
    logic [15:0] sig;
`endif

    int errors = 0;
    int checks = 0;

    scan_test_ctrl #(.CHAIN_LEN(N)) dut (
        .C           (C),
        .CLRbar      (CLRbar),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .expected    (expected),
        .so_in       (so_in),
        .NbarT       (NbarT),
        .Si          (Si),
        .CE          (CE),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
`ifdef SCAN_TEST_CTRL_MISR_EN
        .sig         (sig),
`endif
        .mismatch_cnt(mismatch_cnt)
    );

    always #5 C = ~C;

    // Chain of scan dff cells: Si enters cell 0, cell 3 drives scan-out.
    always @(posedge C or negedge CLRbar) begin
        if (!CLRbar) chain <= '0;
        else if (NbarT) chain <= {chain[2:0], Si};
        else if (CE) chain <= CAPTURE_VAL;
    end
    assign so_in = chain[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    function automatic logic [15:0] misr_ref(input logic [3:0] bits);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int i = 3; i >= 0; i--) begin
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ bits[i]};
        end
        return s;
    endfunction

    // Full test; done is expected 2N+1 edges after the accepting edge (i.e. in cycle 2N+2).
    task automatic run_test(input logic [3:0] pat, input logic [3:0] exp_v,
                            input logic exp_fail, input logic [2:0] exp_cnt);
        int done_at;
        pattern  = pat;
        expected = exp_v;
        start    = 1'b1;
        step();
        start    = 1'b0;
        pattern  = ~pat;
        expected = ~exp_v;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("nbart_after_accept", 32'(NbarT), 32'd1);
        chk("si_first_bit", 32'(Si), 32'(pat[3]));
        done_at = -1;
        for (int k = 1; k <= 20 && done_at < 0; k++) begin
            step();
            if (k == N) begin
                chk("ce_in_capture", 32'(CE), 32'd1);
                chk("chain_pre_capture", 32'(chain), 32'(pat));
            end
            if (done) done_at = k;
        end
        chk("done_edge", 32'(done_at), 32'(2 * N + 1));
        chk("fail", 32'(fail), 32'(exp_fail));
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_cnt));
`ifdef SCAN_TEST_CTRL_MISR_EN
        chk("sig", 32'(sig), 32'(misr_ref(CAPTURE_VAL)));
`endif
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_nbart", 32'(NbarT), 32'd0);
        chk("rst_ce", 32'(CE), 32'd0);
        chk("rst_si", 32'(Si), 32'd0);
        chk("rst_cnt", 32'(mismatch_cnt), 32'd0);
`ifdef SCAN_TEST_CTRL_MISR_EN
        chk("rst_sig", 32'(sig), 32'hFFFF);
`endif
        @(negedge C);
        CLRbar = 1'b1;
        step();

        // Case 1: matching response.
        run_test(4'b1011, 4'b0110, 1'b0, 3'd0);
        // Case 2: two bits differ (0110 vs 0101).
        run_test(4'b1011, 4'b0101, 1'b1, 3'd2);
        chk("fail_holds_in_idle", 32'(fail), 32'd1);

        // abort and start together in IDLE: start dropped.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'd0);

        // Case 3: abort during UNLOAD idx 2 (edges 1-4 shift, 5 capture, 6-7 unload idx 0-1).
        pattern  = 4'b1011;
        expected = 4'b0101;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        chk("unload_shifting", 32'(NbarT), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_nbart", 32'(NbarT), 32'd0);
        chk("abort_ce", 32'(CE), 32'd0);
        chk("abort_si", 32'(Si), 32'd0);
        chk("abort_fail_cleared", 32'(fail), 32'd0);
        ndone = int'(done);
        for (int k = 0; k < 4; k++) begin
            step();
            ndone += int'(done);
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Case 4: asynchronous reset mid SHIFT_IN.
        pattern = 4'b1011;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("mid_shift_busy", 32'(busy), 32'd1);
        CLRbar = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_nbart", 32'(NbarT), 32'd0);
        chk("async_rst_si", 32'(Si), 32'd0);
        @(negedge C);
        CLRbar = 1'b1;
        step();
        run_test(4'b1011, 4'b0110, 1'b0, 3'd0);

        // Case 5: start held high across a whole test.
        pattern  = 4'b1011;
        expected = 4'b0101;
        start    = 1'b1;
        step();
        ndone = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            ndone += int'(done);
        end
        start = 1'b0;
        chk("one_done_per_test", 32'(ndone), 32'd1);
        chk("start_held_cnt", 32'(mismatch_cnt), 32'd2);
        step();
        chk("start_held_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
